// File: rtl/rca_config_scheduler.sv
// In-order scheduler for RCA reconfiguration writes: config instructions are queued and each
// is committed to config storage only once its target RCA has no use instructions in flight.
module rca_config_scheduler #(
    parameter int NUM_RCAS        = 4,
    parameter int CFG_FIFO_DEPTH  = 4,
    parameter int MAX_INFLIGHT    = 3,
    parameter int CFG_ADDR_W      = 8,
    parameter int CFG_DATA_W      = 16,
    localparam int RCA_W          = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [RCA_W-1:0]      cfg_rca,
    input  logic [2:0]            cfg_type,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [CFG_DATA_W-1:0] cfg_data,
    input  logic                  use_issue,
    input  logic [RCA_W-1:0]      use_issue_rca,
    input  logic                  use_complete,
    input  logic [RCA_W-1:0]      use_complete_rca,
    output logic [NUM_RCAS-1:0]   rca_use_blocked,
    output logic                  cfg_wr_en,
    output logic [RCA_W-1:0]      cfg_wr_rca,
    output logic [2:0]            cfg_wr_type,
    output logic [CFG_ADDR_W-1:0] cfg_wr_addr,
    output logic [CFG_DATA_W-1:0] cfg_wr_data,
    output logic                  busy
);

    localparam int PTR_W = $clog2(CFG_FIFO_DEPTH);
    localparam int CNT_W = $clog2(CFG_FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_FIFO_DEPTH);
    localparam logic [INF_W-1:0] INF_MAX  = INF_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [RCA_W-1:0]      q_rca  [CFG_FIFO_DEPTH];
    logic [2:0]            q_type [CFG_FIFO_DEPTH];
    logic [CFG_ADDR_W-1:0] q_addr [CFG_FIFO_DEPTH];
    logic [CFG_DATA_W-1:0] q_data [CFG_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      q_count;

    logic [CNT_W-1:0]      pending_cnt  [NUM_RCAS];
    logic [INF_W-1:0]      inflight     [NUM_RCAS];
    logic [INF_W-1:0]      inflight_nxt [NUM_RCAS];

    logic                  accept;
    logic                  pop;
    logic [RCA_W-1:0]      head_rca;
    logic [NUM_RCAS-1:0]   accept_hit;
    logic [NUM_RCAS-1:0]   pop_hit;
    logic [NUM_RCAS-1:0]   issue_hit;
    logic [NUM_RCAS-1:0]   complete_hit;

    assign cfg_ready = (q_count != FULL_CNT);
    assign accept    = cfg_valid & cfg_ready;
    assign pop       = (state == WRITE);
    assign head_rca  = q_rca[rd_ptr];
    assign busy      = (state != IDLE) | (q_count != '0);

    always_comb begin
        accept_hit   = '0;
        pop_hit      = '0;
        issue_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < NUM_RCAS; i++) begin
            accept_hit[i]   = accept && (cfg_rca == RCA_W'(i));
            pop_hit[i]      = pop && (head_rca == RCA_W'(i));
            issue_hit[i]    = use_issue && (use_issue_rca == RCA_W'(i));
            complete_hit[i] = use_complete && (use_complete_rca == RCA_W'(i));
        end
    end

    // Queue payload carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_rca[wr_ptr]  <= cfg_rca;
            q_type[wr_ptr] <= cfg_type;
            q_addr[wr_ptr] <= cfg_addr;
            q_data[wr_ptr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                q_count <= q_count + CNT_W'(1);
            end else if (pop && !accept) begin
                q_count <= q_count - CNT_W'(1);
            end
        end
    end

    // Simultaneous issue and complete on one RCA cancel; saturation and underflow are held off.
    always_comb begin
        for (int i = 0; i < NUM_RCAS; i++) begin
            inflight_nxt[i] = inflight[i];
            if (issue_hit[i] && !complete_hit[i] && (inflight[i] != INF_MAX)) begin
                inflight_nxt[i] = inflight[i] + INF_W'(1);
            end else if (complete_hit[i] && !issue_hit[i] && (inflight[i] != '0)) begin
                inflight_nxt[i] = inflight[i] - INF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                inflight[i]    <= '0;
                pending_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                inflight[i] <= inflight_nxt[i];
                if (accept_hit[i] && !pop_hit[i]) begin
                    pending_cnt[i] <= pending_cnt[i] + CNT_W'(1);
                end else if (pop_hit[i] && !accept_hit[i]) begin
                    pending_cnt[i] <= pending_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RCAS; i++) begin
            rca_use_blocked[i] = (pending_cnt[i] != '0) | (inflight[i] == INF_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN looks at the next inflight value so the write follows the edge of the last completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (q_count != '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_nxt[head_rca] == '0) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_wr_en   = 1'b0;
        cfg_wr_rca  = '0;
        cfg_wr_type = '0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        if (state == WRITE) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_rca  = q_rca[rd_ptr];
            cfg_wr_type = q_type[rd_ptr];
            cfg_wr_addr = q_addr[rd_ptr];
            cfg_wr_data = q_data[rd_ptr];
        end
    end

endmodule

// File: tb/tb_rca_config_scheduler.sv
// Directed bench for rca_config_scheduler: each accepted config pushes its expected write
// (fields and, where hand-computed, the write cycle) and a negedge monitor matches writes.
`timescale 1ns/1ps
module tb_rca_config_scheduler;

    typedef struct {
        logic [1:0]  rca;
        logic [2:0]  typ;
        logic [7:0]  addr;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_rca = '0;
    logic [2:0]  cfg_type = '0;
    logic [7:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        use_issue = 1'b0;
    logic [1:0]  use_issue_rca = '0;
    logic        use_complete = 1'b0;
    logic [1:0]  use_complete_rca = '0;
    logic [3:0]  rca_use_blocked;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_rca;
    logic [2:0]  cfg_wr_type;
    logic [7:0]  cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        prev_wr = 1'b0;

    rca_config_scheduler #(
        .NUM_RCAS       (4),
        .CFG_FIFO_DEPTH (4),
        .MAX_INFLIGHT   (3),
        .CFG_ADDR_W     (8),
        .CFG_DATA_W     (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_rca          (cfg_rca),
        .cfg_type         (cfg_type),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .use_issue        (use_issue),
        .use_issue_rca    (use_issue_rca),
        .use_complete     (use_complete),
        .use_complete_rca (use_complete_rca),
        .rca_use_blocked  (rca_use_blocked),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_wr_rca       (cfg_wr_rca),
        .cfg_wr_type      (cfg_wr_type),
        .cfg_wr_addr      (cfg_wr_addr),
        .cfg_wr_data      (cfg_wr_data),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: matches each write against the scoreboard and watches the issue protocol.
    always @(negedge clk) begin
        if (rst_n) begin
            if (use_issue) begin
                check_output("issue_to_blocked_rca", {31'd0, rca_use_blocked[use_issue_rca]}, 32'd0);
            end
            if (cfg_wr_en) begin
                check_output("wr_en_back_to_back", {31'd0, prev_wr}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_write: got rca=%0d type=%0d addr=0x%0h data=0x%0h, required no write",
                             cfg_wr_rca, cfg_wr_type, cfg_wr_addr, cfg_wr_data);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("wr_rca",  {30'd0, cfg_wr_rca},  {30'd0, mon_e.rca});
                    check_output("wr_type", {29'd0, cfg_wr_type}, {29'd0, mon_e.typ});
                    check_output("wr_addr", {24'd0, cfg_wr_addr}, {24'd0, mon_e.addr});
                    check_output("wr_data", {16'd0, cfg_wr_data}, {16'd0, mon_e.data});
                    if (mon_e.due >= 0) begin
                        check_output("wr_cycle", cyc, mon_e.due);
                    end
                end
            end
            prev_wr = cfg_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    // Offers one config and waits (bounded) for acceptance; due_off < 0 means write cycle not checked.
    task automatic apply_stimulus(input logic [1:0] rca, input logic [2:0] typ, input logic [7:0] addr,
                                  input logic [15:0] data, input int due_off, output int acc_edge);
        cfg_rca   = rca;
        cfg_type  = typ;
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_valid = 1'b1;
        acc_edge  = -1;
        for (int n = 0; n < 60; n++) begin
            if (cfg_ready) begin
                tick();
                acc_edge = cyc;
                sb.push_back('{rca, typ, addr, data, (due_off < 0) ? -1 : acc_edge + due_off});
                break;
            end
            tick();
        end
        cfg_valid = 1'b0;
        if (acc_edge < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL cfg_accept_timeout: got no accept in 60 cycles, required accept");
        end
    endtask

    task automatic use_op(input logic iss, input logic [1:0] irca, input logic cmp, input logic [1:0] crca);
        use_issue        = iss;
        use_issue_rca    = irca;
        use_complete     = cmp;
        use_complete_rca = crca;
        tick();
        use_issue    = 1'b0;
        use_complete = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int n = 0; n < limit; n++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        check_output("drain_done", {31'd0, (sb.size() == 0) && !busy}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200us, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e, b, d, e5;

        repeat (2) tick();
        check_output("reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check_output("reset_wr_en", {31'd0, cfg_wr_en}, 32'd0);
        check_output("reset_blocked", {28'd0, rca_use_blocked}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Idle RCA 1: write two cycles after accept, blocked only while pending.
        apply_stimulus(2'd1, 3'd2, 8'h05, 16'h0003, 2, e);
        tick();
        check_output("t1_blocked_c1", {28'd0, rca_use_blocked}, 32'h2);
        check_output("t1_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        check_output("t1_blocked_c2", {28'd0, rca_use_blocked}, 32'h2);
        tick();
        check_output("t1_blocked_c3", {28'd0, rca_use_blocked}, 32'h0);
        wait_idle(20);

        // RCA 0 with two uses in flight; completions in cycles 4 and 7 give write in cycle 8.
        use_op(1'b1, 2'd0, 1'b0, 2'd0);
        use_op(1'b1, 2'd0, 1'b0, 2'd0);
        apply_stimulus(2'd0, 3'd4, 8'h21, 16'hBEEF, 8, e);
        repeat (4) tick();
        check_output("t2_blocked0_c4", {31'd0, rca_use_blocked[0]}, 32'd1);
        use_op(1'b0, 2'd0, 1'b1, 2'd0);
        repeat (2) tick();
        use_op(1'b0, 2'd0, 1'b1, 2'd0);
        check_output("t2_blocked0_c8", {31'd0, rca_use_blocked[0]}, 32'd1);
        tick();
        check_output("t2_blocked0_c9", {31'd0, rca_use_blocked[0]}, 32'd0);
        wait_idle(20);

        // Five configs to busy RCA 2: queue fills, fifth enters after the first pop.
        use_op(1'b1, 2'd2, 1'b0, 2'd0);
        apply_stimulus(2'd2, 3'd0, 8'h10, 16'h0001, 4, b);
        apply_stimulus(2'd2, 3'd1, 8'h11, 16'h0002, 6, e);
        apply_stimulus(2'd2, 3'd3, 8'h12, 16'h0003, 8, e);
        apply_stimulus(2'd2, 3'd4, 8'h13, 16'h0004, 10, e);
        check_output("t3_fourth_edge", e, b + 3);
        check_output("t3_ready_full", {31'd0, cfg_ready}, 32'd0);
        use_complete     = 1'b1;
        use_complete_rca = 2'd2;
        tick();
        use_complete = 1'b0;
        check_output("t3_ready_during_write", {31'd0, cfg_ready}, 32'd0);
        apply_stimulus(2'd2, 3'd5, 8'h14, 16'h0005, 10, e5);
        check_output("t3_fifth_edge", e5, b + 6);
        wait_idle(40);

        // Same-cycle issue and complete on RCA 2 leaves one use in flight.
        use_op(1'b1, 2'd2, 1'b0, 2'd0);
        use_op(1'b1, 2'd2, 1'b1, 2'd2);
        apply_stimulus(2'd2, 3'd5, 8'h33, 16'h00A5, 6, e);
        repeat (4) tick();
        check_output("t4_blocked2_c4", {31'd0, rca_use_blocked[2]}, 32'd1);
        tick();
        use_op(1'b0, 2'd0, 1'b1, 2'd2);
        wait_idle(20);

        // Busy RCA 3 (use issued with the accept) ahead of idle RCA 0: strict order.
        use_issue     = 1'b1;
        use_issue_rca = 2'd3;
        apply_stimulus(2'd3, 3'd3, 8'h40, 16'h1234, 4, d);
        use_issue = 1'b0;
        apply_stimulus(2'd0, 3'd1, 8'h41, 16'h5678, 6, e);
        check_output("t5_blocked_c1", {28'd0, rca_use_blocked}, 32'h9);
        repeat (2) tick();
        use_op(1'b0, 2'd0, 1'b1, 2'd3);
        wait_idle(20);

        // Complete at zero ignored, saturation blocks, reserved type written through.
        use_op(1'b0, 2'd0, 1'b1, 2'd1);
        use_op(1'b1, 2'd1, 1'b0, 2'd0);
        use_op(1'b1, 2'd1, 1'b0, 2'd0);
        use_op(1'b1, 2'd1, 1'b0, 2'd0);
        check_output("t6_blocked_full", {28'd0, rca_use_blocked}, 32'h2);
        repeat (3) use_op(1'b0, 2'd0, 1'b1, 2'd1);
        check_output("t6_blocked_clear", {28'd0, rca_use_blocked}, 32'h0);
        apply_stimulus(2'd1, 3'd6, 8'hFF, 16'hFFFF, 2, e);
        wait_idle(20);

        // Reset mid-DRAIN with three queued configs discards them.
        use_op(1'b1, 2'd1, 1'b0, 2'd0);
        apply_stimulus(2'd1, 3'd0, 8'h50, 16'h0050, -1, e);
        apply_stimulus(2'd1, 3'd1, 8'h51, 16'h0051, -1, e);
        apply_stimulus(2'd1, 3'd2, 8'h52, 16'h0052, -1, e);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t7_rst_ready", {31'd0, cfg_ready}, 32'd1);
        check_output("t7_rst_wr_en", {31'd0, cfg_wr_en}, 32'd0);
        check_output("t7_rst_wr_fields", {cfg_wr_data, cfg_wr_addr, 3'd0, cfg_wr_type, cfg_wr_rca}, 32'd0);
        check_output("t7_rst_blocked", {28'd0, rca_use_blocked}, 32'h0);
        check_output("t7_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check_output("t7_post_ready", {31'd0, cfg_ready}, 32'd1);
        check_output("t7_post_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_config_scheduler.md
# rca_config_scheduler

Schedules reconfiguration writes for the reconfigurable custom accelerators (RCAs), sitting between issue and the RCA config storage. This covers CPU src/dest register addresses, grid MUX, IO MUX, result MUX and IO-use selects. Config instructions are queued in order and applied one at a time, only after the target RCA has drained all in-flight use instructions. While an RCA has config pending, further use instructions to it are blocked.

## Interface
Parameters:
- NUM_RCAS, 4: number of RCAs; RCA_W = max(1, $clog2(NUM_RCAS)).
- CFG_FIFO_DEPTH, 4: config queue entries (power of 2, ≥2).
- MAX_INFLIGHT, 3: max outstanding use instructions per RCA.
- CFG_ADDR_W, 8: config storage address width.
- CFG_DATA_W, 16: config write data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config instruction offered.
- cfg_ready  out  1  queue not full; transfer on cfg_valid & cfg_ready.
- cfg_rca  in  RCA_W  target RCA.
- cfg_type  in  3  0 fb_cpu_reg, 1 nfb_cpu_reg, 2 grid_mux, 3 io_mux, 4 result_mux, 5 io_use; 6–7 reserved (written through, no check).
- cfg_addr  in  CFG_ADDR_W  storage address within type.
- cfg_data  in  CFG_DATA_W  new select/address value.
- use_issue  in  1  use instruction issued this cycle.
- use_issue_rca  in  RCA_W  its RCA.
- use_complete  in  1  use instruction wrote back this cycle.
- use_complete_rca  in  RCA_W  its RCA.
- rca_use_blocked  out  NUM_RCAS  bit i: issue must not send a use to RCA i.
- cfg_wr_en  out  1  one-cycle write strobe to config storage.
- cfg_wr_rca / cfg_wr_type / cfg_wr_addr / cfg_wr_data  out  RCA_W/3/CFG_ADDR_W/CFG_DATA_W  write fields, valid when cfg_wr_en.
- busy  out  1  FSM not IDLE or queue non-empty.

## Operation
- Queue: FIFO of {rca,type,addr,data}, strict order (head-of-line blocking across RCAs is intended). cfg_ready = !full; it is registered-derived and does not depend on cfg_valid.
- pending_cnt[i] (width $clog2(CFG_FIFO_DEPTH+1)): increments on accept for RCA i and decrements on the WRITE cycle for RCA i. Both in one cycle means no change.
- inflight[i] (width $clog2(MAX_INFLIGHT+1)): increments on use_issue and decrements on use_complete. Both for the same RCA in one cycle means no change. Complete at 0 is ignored. Issue at MAX_INFLIGHT holds the value (protocol violation, assertion in bench).
- rca_use_blocked[i] = (pending_cnt[i] != 0) | (inflight[i] == MAX_INFLIGHT). Combinational from registers only.
- FSM:
  - IDLE: if queue non-empty, go to DRAIN.
  - DRAIN: if inflight[head.rca] == 0, go to WRITE; otherwise stay.
  - WRITE: drive cfg_wr_en=1 with the head fields, pop the queue, go to IDLE.
- A use issued in the same cycle a config is accepted for that RCA is counted and must drain before the write.
- Reset (any time, including mid-DRAIN/WRITE): queue emptied, all counters 0, FSM IDLE, queued configs discarded. Outputs take reset values immediately: cfg_ready=1, cfg_wr_en=0, all wr fields 0, rca_use_blocked=0, busy=0.

## Timing
- Accept at edge N with target RCA idle: DRAIN at N+1, WRITE at N+2. cfg_wr_en is high in the cycle N+2..N+3, so minimum latency is 2 cycles.
- rca_use_blocked[i] rises in the cycle after the accepting edge N and falls in the cycle after the WRITE edge if there is no further pending config for i.
- Target RCA busy: DRAIN holds. WRITE follows the edge at which inflight reaches 0, i.e. cfg_wr_en is high in the cycle after the last use_complete cycle.
- Throughput: one write per 3 cycles. A full queue accepts a new entry in the cycle after a WRITE pop.
- cfg_wr_en is never high on consecutive cycles.

## Test plan
- Idle RCA 1, config {type=2, addr=5, data=0x3} accepted at edge 0 -> cfg_wr_en high in cycle 2 with those fields; rca_use_blocked=4'b0010 during cycles 1–2, 0 from cycle 3.
- RCA 0 with inflight=2, config accepted, completes at cycles 4 and 7 -> no write until cfg_wr_en is high in cycle 8; rca_use_blocked[0] high throughout.
- Push 5 configs back-to-back to a busy RCA with depth 4 -> cfg_ready low after 4 accepts; the 5th is accepted in the cycle after the first WRITE; write order matches push order.
- Same-cycle use_issue and use_complete for RCA 2 at inflight=1 -> inflight stays 1; a config to RCA 2 waits for one more completion.
- Configs for RCA 3 (busy) then RCA 0 (idle) -> RCA 0 write is not issued before RCA 3's write (in-order).
- Assert rst_n low while in DRAIN with 3 entries queued -> all outputs at reset values asynchronously; after release, no write occurs, cfg_ready=1, busy=0.
